// File: rtl/ray_dir_gen.sv
// Per-column ray direction generator: ray_dir = dir + plane * cameraX (signed Q8.8).
// Walks columns 0..NUM_COLS-1, 3 cycles per column, and holds each result until the consumer accepts it.
module ray_dir_gen #(
    parameter int NUM_COLS = 320,
    parameter int COL_W    = 9,
    parameter int FRAC     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      dir_x,
    input  logic [15:0]      dir_y,
    input  logic [15:0]      plane_x,
    input  logic [15:0]      plane_y,
    output logic [COL_W-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] out_col,
    output logic [15:0]      ray_dir_x,
    output logic [15:0]      ray_dir_y,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CALC, S_OUT} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]      dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [15:0]      plane_x_q, plane_x_d, plane_y_q, plane_y_d;
    logic [15:0]      ray_x_q, ray_x_d, ray_y_q, ray_y_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    // Operands are sign-extended to full product width so the multiply is exact.
    logic signed [31:0] plane_x_ext, plane_y_ext, cam_ext;
    logic signed [31:0] prod_x, prod_y;
    logic [15:0]        sum_x, sum_y;
    logic               unused_prod_bits;

    assign plane_x_ext = {{16{plane_x_q[15]}}, plane_x_q};
    assign plane_y_ext = {{16{plane_y_q[15]}}, plane_y_q};
    assign cam_ext     = {{16{rom_data[15]}}, rom_data};
    assign prod_x      = plane_x_ext * cam_ext;
    assign prod_y      = plane_y_ext * cam_ext;

    // Bit-slicing the product is an arithmetic shift that rounds toward -inf; the add wraps mod 2^16.
    assign sum_x = dir_x_q + prod_x[FRAC+15:FRAC];
    assign sum_y = dir_y_q + prod_y[FRAC+15:FRAC];

    assign unused_prod_bits = ^{prod_x[31:FRAC+16], prod_x[FRAC-1:0],
                                prod_y[31:FRAC+16], prod_y[FRAC-1:0]};

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        rom_addr_d  = rom_addr_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        plane_x_d   = plane_x_q;
        plane_y_d   = plane_y_q;
        ray_x_d     = ray_x_q;
        ray_y_d     = ray_y_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_x_d    = dir_x;
                    dir_y_d    = dir_y;
                    plane_x_d  = plane_x;
                    plane_y_d  = plane_y;
                    col_d      = '0;
                    rom_addr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                ray_x_d     = sum_x;
                ray_y_d     = sum_y;
                out_col_d   = col_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (col_q == LAST_COL) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        col_d      = col_q + COL_W'(1);
                        rom_addr_d = col_q + COL_W'(1);
                        state_d    = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            rom_addr_q  <= '0;
            dir_x_q     <= '0;
            dir_y_q     <= '0;
            plane_x_q   <= '0;
            plane_y_q   <= '0;
            ray_x_q     <= '0;
            ray_y_q     <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            rom_addr_q  <= rom_addr_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            plane_x_q   <= plane_x_d;
            plane_y_q   <= plane_y_d;
            ray_x_q     <= ray_x_d;
            ray_y_q     <= ray_y_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign ray_dir_x = ray_x_q;
    assign ray_dir_y = ray_y_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_ray_dir_gen.sv
// Bench for ray_dir_gen: synchronous camera-X ROM model, directed frames, queue-based scoreboard.
module tb_ray_dir_gen;

    typedef struct {
        logic [8:0]  col;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dir_x = '0, dir_y = '0, plane_x = '0, plane_y = '0;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_col;
    logic [15:0] ray_dir_x, ray_dir_y;
    logic        busy, done;

    logic [15:0] rom [320];
    exp_t        exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    ray_dir_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .plane_x   (plane_x),
        .plane_y   (plane_y),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .ray_dir_x (ray_dir_x),
        .ray_dir_y (ray_dir_y),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] p,
                                          input logic [15:0] c);
        int pr;
        int sum;
        pr  = int'($signed(p)) * int'($signed(c));
        sum = int'(d) + (pr >>> 8);
        return sum[15:0];
    endfunction

    task automatic push_frame(input logic [15:0] dx, input logic [15:0] dy,
                              input logic [15:0] px, input logic [15:0] py);
        exp_t e;
        for (int c = 0; c < 320; c++) begin
            e.col = 9'(c);
            e.x   = model(dx, px, rom[c]);
            e.y   = model(dy, py, rom[c]);
            exp_q.push_back(e);
        end
    endtask

    task automatic patch(input int idx, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        e = exp_q[idx];
        e.x = x;
        e.y = y;
        exp_q[idx] = e;
    endtask

    // Start issued in cycle T; checks FETCH/CALC cycles and first valid at T+3.
    task automatic start_frame(input logic [15:0] dx, input logic [15:0] dy,
                               input logic [15:0] px, input logic [15:0] py);
        @(negedge clk);
        dir_x = dx; dir_y = dy; plane_x = px; plane_y = py;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fetch_valid", 32'(out_valid), 32'd0);
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        chk("calc_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_col", 32'(out_col), 32'd0);
    endtask

    task automatic wait_col(input int c);
        int n = 0;
        while (!(out_valid === 1'b1 && out_col == 9'(c)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_col: column %0d never presented, expected within 2000 cycles", c);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: busy=%b, expected 0 within 3000 cycles", busy);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_addr"},  32'(rom_addr),  32'd0);
        chk({tag, "_col"},   32'(out_col),   32'd0);
        chk({tag, "_rx"},    32'(ray_dir_x), 32'd0);
        chk({tag, "_ry"},    32'(ray_dir_y), 32'd0);
    endtask

    // Scoreboard monitor
    exp_t        m_e;
    logic        m_pv = 1'b0, m_pr = 1'b0, m_dexp = 1'b0;
    logic [8:0]  m_pc = '0;
    logic [15:0] m_px = '0, m_py = '0;
    int          m_lhs = -1;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                m_pv = 1'b0; m_dexp = 1'b0; m_lhs = -1;
            end else begin
                if (done === 1'b1 || m_dexp) chk("done_pulse", 32'(done), 32'(m_dexp));
                if (m_pv && !m_pr) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_col", 32'(out_col), 32'(m_pc));
                    chk("stall_x", 32'(ray_dir_x), 32'(m_px));
                    chk("stall_y", 32'(ray_dir_y), 32'(m_py));
                end
                if (out_valid === 1'b1 && !m_pv && m_lhs >= 0)
                    chk("col_period", 32'(cyc - m_lhs), 32'd3);
                m_dexp = 1'b0;
                if (out_valid === 1'b1 && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_result: col %0d, expected no output", out_col);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("res_col", 32'(out_col), 32'(m_e.col));
                        chk("res_x", 32'(ray_dir_x), 32'(m_e.x));
                        chk("res_y", 32'(ray_dir_y), 32'(m_e.y));
                        chk("addr_range", 32'(rom_addr <= 9'd319), 32'd1);
                        m_dexp = (m_e.col == 9'd319);
                        m_lhs  = m_dexp ? -1 : cyc;
                    end
                end
                m_pv = out_valid; m_pr = out_ready;
                m_pc = out_col; m_px = ray_dir_x; m_py = ray_dir_y;
            end
        end
    end

    initial begin
        int v;
        for (int i = 0; i < 320; i++) begin
            v = (i * 512) / 320 - 256;
            rom[i] = v[15:0];
        end
        rom[1] = 16'h0100;
        rom[2] = 16'h0080;

        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: hand vector on col 0, full frame, start coincident with final handshake.
        push_frame(16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
        patch(0, 16'hFF00, 16'hFF57);
        start_frame(16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
        wait_col(319);
        start = 1'b1;
        dir_x = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        chk("final_idle", 32'(busy), 32'd0);
        chk("final_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("final_start_ignored", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);

        // Frame 2: wrap and -1 term vectors, stall at col 7, start while busy.
        push_frame(16'h7F00, 16'h0000, 16'h0200, 16'hFFFF);
        patch(1, 16'h8100, 16'hFFFF);
        patch(2, 16'h8000, 16'hFFFF);
        start_frame(16'h7F00, 16'h0000, 16'h0200, 16'hFFFF);
        wait_col(7);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_addr", 32'(rom_addr), 32'd7);
            chk("stall_hold_col", 32'(out_col), 32'd7);
        end
        out_ready = 1'b1;
        wait_col(20);
        start = 1'b1;
        dir_x = 16'h1234; dir_y = 16'h4321; plane_x = 16'h4000; plane_y = 16'hC000;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_busy", 32'(busy), 32'd1);
        wait_idle();

        // Frame 3: start from IDLE accepted, reset at col 100.
        push_frame(16'h0100, 16'hFF80, 16'h0080, 16'h0100);
        start_frame(16'h0100, 16'hFF80, 16'h0080, 16'h0100);
        wait_col(100);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_done", 32'(done), 32'd0);
            chk("post_reset_busy", 32'(busy), 32'd0);
        end

        // Frame 4: restart after reset begins at col 0 with T+3 latency.
        push_frame(16'h0000, 16'h0100, 16'h0100, 16'h0000);
        start_frame(16'h0000, 16'h0100, 16'h0100, 16'h0000);
        wait_idle();
        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
